// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning stage.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic KEY_PRESSED = 1'b0;

    // Ceiling log2, never less than one bit so counters always have a width.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          w;
        w = 0;
        if (value > 32'd1) begin
            v = value - 32'd1;
            while (v > 32'd0) begin
                w = w + 1;
                v = v >> 1;
            end
        end else begin
            w = 0;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (keys, switches).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic s0_q;
    logic s1_q;

    // Metastability chain; both stages preset so the input reads as idle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s0_q <= RESET_VAL;
            s1_q <= RESET_VAL;
        end else begin
            s0_q <= D;
            s1_q <= s0_q;
        end
    end

    assign Q = s1_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: clean level plus one-cycle PRESS/RELEASE pulses.
// Optional auto-repeat of PRESS while held: define KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_N,
    output logic LEVEL,
    output logic PRESS,
    output logic RELEASE
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             key_sync;
    logic             key_down;
    logic             press_accept;
    logic             repeat_hit;

    sync_2ff #(
        .RESET_VAL (~KEY_PRESSED)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (KEY_N),
        .Q   (key_sync)
    );

    assign key_down     = (key_sync == KEY_PRESSED);
    assign press_accept = (state_q == PRESS_WAIT) && key_down && (cnt_q == CNT_LAST);

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int RCNT_W = clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RCNT_W-1:0] RPT_FIRST = RCNT_W'(REPEAT_DELAY - 32'd1);
    localparam logic [RCNT_W-1:0] RPT_NEXT  = RCNT_W'(REPEAT_PERIOD - 32'd1);

    logic [RCNT_W-1:0] rcnt_q;
    logic [RCNT_W-1:0] rcnt_d;
    logic              rphase_q;
    logic              rphase_d;

    // Repeat timer: restarts on a fresh press, frozen outside HELD; rphase selects delay vs period.
    always_comb begin
        rcnt_d     = rcnt_q;
        rphase_d   = rphase_q;
        repeat_hit = 1'b0;
        if (press_accept) begin
            rcnt_d   = {RCNT_W{1'b0}};
            rphase_d = 1'b0;
        end else if (state_q == HELD) begin
            if (rcnt_q == (rphase_q ? RPT_NEXT : RPT_FIRST)) begin
                repeat_hit = 1'b1;
                rcnt_d     = {RCNT_W{1'b0}};
                rphase_d   = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RCNT_W'(1'b1);
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rcnt_q   <= {RCNT_W{1'b0}};
            rphase_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rphase_q <= rphase_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // Debounce FSM next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = repeat_hit;
        release_d = 1'b0;
        level_d   = level_q;
        case (state_q)
            IDLE: begin
                if (key_down) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!key_down) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            HELD: begin
                if (!key_down) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (key_down) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign LEVEL   = level_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
module tb_key_debouncer;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK;
    logic RST;
    logic KEY_N;
    logic LEVEL;
    logic PRESS;
    logic RELEASE;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: synchronizer as a raw-sample FIFO, debounce as a disagreement run length.
    logic m_hist[$];
    logic m_level;
    logic m_press;
    logic m_release;
    int   m_run;
    int   m_held;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .KEY_N   (KEY_N),
        .LEVEL   (LEVEL),
        .PRESS   (PRESS),
        .RELEASE (RELEASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_hist    = {1'b1, 1'b1};
        m_level   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_run     = 0;
        m_held    = 0;
    endtask

    task automatic model_step(input logic k);
        logic down;
        bit   in_held;
        m_hist.push_back(k);
        down      = (m_hist.pop_front() == 1'b0);
        m_press   = 1'b0;
        m_release = 1'b0;
        in_held   = m_level && (m_run == 0);
        if (down != m_level) begin
            m_run = m_run + 1;
            if (m_run == DC + 1) begin
                m_level = down;
                m_run   = 0;
                if (down) begin
                    m_press = 1'b1;
                    m_held  = 0;
                end else begin
                    m_release = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        if (in_held) begin
            m_held = m_held + 1;
            if (m_held == RD || (m_held > RD && ((m_held - RD) % RP) == 0))
                m_press = 1'b1;
        end
`else
        if (in_held) m_held = m_held + 1;
`endif
    endtask

    task automatic tick(input logic k);
        KEY_N = k;
        RST   = 1'b1;
        @(posedge CLK);
        model_step(k);
        @(negedge CLK);
    endtask

    task automatic reset_tick(input logic k);
        KEY_N = k;
        RST   = 1'b0;
        @(posedge CLK);
        model_reset();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            reset_tick(1'b0);
            n_checks++;
            if ({LEVEL, PRESS, RELEASE} !== 3'b000)
                $display("FAIL reset cyc %0d: got LPR=%b%b%b want 000", i, LEVEL, PRESS, RELEASE);
            else n_pass++;
        end
        tick(1'b0);
        n_checks++;
        if ({LEVEL, PRESS, RELEASE} !== 3'b000)
            $display("FAIL reset_exit: got LPR=%b%b%b want 000", LEVEL, PRESS, RELEASE);
        else n_pass++;
        reset_tick(1'b1);
    endtask

    task automatic settle_released();
        for (int i = 0; i < 12; i++) tick(1'b1);
        n_checks++;
        if ({LEVEL, PRESS, RELEASE} !== 3'b000)
            $display("FAIL settle: got LPR=%b%b%b want 000", LEVEL, PRESS, RELEASE);
        else n_pass++;
    endtask

    task automatic test_clean_press();
        settle_released();
        for (int i = 0; i < 12; i++) begin
            tick(1'b0);
            n_checks++;
            if (PRESS !== (i == 6) || LEVEL !== (i >= 6) || RELEASE !== 1'b0)
                $display("FAIL clean_press t%0d: got LPR=%b%b%b want %b%b0", i + 1,
                         LEVEL, PRESS, RELEASE, (i >= 6), (i == 6));
            else n_pass++;
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            n_checks++;
            if (RELEASE !== (i == 6) || LEVEL !== (i < 6) || PRESS !== 1'b0)
                $display("FAIL clean_release t%0d: got LPR=%b%b%b want %b0%b", i + 1,
                         LEVEL, PRESS, RELEASE, (i < 6), (i == 6));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int presses;
        int rel_at;
        settle_released();
        presses = 0;
        for (int i = 0; i < 4 + 10; i++) begin
            tick((i < 4) ? 1'b0 : 1'b1);
            if (PRESS === 1'b1) presses++;
            n_checks++;
            if (LEVEL !== 1'b0)
                $display("FAIL glitch4_level t%0d: got %b want 0", i + 1, LEVEL);
            else n_pass++;
        end
        n_checks++;
        if (presses !== 0) $display("FAIL glitch4_press: got %0d presses want 0", presses);
        else n_pass++;
        presses = 0;
        rel_at  = -1;
        for (int i = 0; i < 5 + 12; i++) begin
            tick((i < 5) ? 1'b0 : 1'b1);
            if (PRESS === 1'b1) presses++;
            if (RELEASE === 1'b1 && rel_at < 0) rel_at = i - 5 + 1;
        end
        n_checks++;
        if (presses !== 1) $display("FAIL glitch5_press: got %0d presses want 1", presses);
        else n_pass++;
        n_checks++;
        if (rel_at !== 7) $display("FAIL glitch5_release: got posedge %0d want 7", rel_at);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic pat[5];
        int   presses;
        int   releases;
        int   at;
        settle_released();
        pat      = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        presses  = 0;
        at       = -1;
        for (int i = 0; i < 15; i++) begin
            tick((i < 5) ? pat[i] : 1'b0);
            if (PRESS === 1'b1) begin presses++; if (at < 0) at = i - 4 + 1; end
            n_checks++;
            if ({LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_release})
                $display("FAIL bounce_model t%0d: got LPR=%b%b%b want %b%b%b", i, LEVEL, PRESS,
                         RELEASE, m_level, m_press, m_release);
            else n_pass++;
        end
        n_checks++;
        if (presses !== 1 || at !== 7)
            $display("FAIL bounce_press: got %0d presses at %0d want 1 at 7", presses, at);
        else n_pass++;
        releases = 0;
        for (int i = 0; i < 15; i++) begin
            tick((i < 5) ? ~pat[i] : 1'b1);
            if (RELEASE === 1'b1) releases++;
        end
        n_checks++;
        if (releases !== 1) $display("FAIL bounce_release: got %0d releases want 1", releases);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        settle_released();
        for (int i = 0; i < 4; i++) tick(1'b0);
        for (int i = 0; i < 2; i++) begin
            reset_tick(1'b0);
            n_checks++;
            if (PRESS !== 1'b0 || LEVEL !== 1'b0)
                $display("FAIL midreset_hold r%0d: got L=%b P=%b want 0 0", i, LEVEL, PRESS);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            n_checks++;
            if (PRESS !== (i == 6))
                $display("FAIL midreset_press t%0d: got %b want %b", i + 1, PRESS, (i == 6));
            else n_pass++;
        end
        settle_released();
    endtask

    task automatic test_autorepeat();
        int got[$];
        int exp[$];
        settle_released();
        exp.push_back(7);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        for (int t = 7 + RD; t <= 30; t += RP) exp.push_back(t);
`endif
        for (int i = 0; i < 30; i++) begin
            tick(1'b0);
            if (PRESS === 1'b1) got.push_back(i + 1);
        end
        n_checks++;
        if (got.size() !== exp.size())
            $display("FAIL repeat_count: got %0d presses want %0d", got.size(), exp.size());
        else n_pass++;
        for (int j = 0; j < exp.size() && j < got.size(); j++) begin
            n_checks++;
            if (got[j] !== exp[j])
                $display("FAIL repeat_time #%0d: got posedge %0d want %0d", j, got[j], exp[j]);
            else n_pass++;
        end
        settle_released();
    endtask

    task automatic test_random();
        logic k;
        int   seg;
        k = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (seg <= 0) begin
                k   = ($urandom_range(0, 3) == 0) ? k : ~k;
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 7);
            end
            seg--;
            if ($urandom_range(0, 299) == 0) reset_tick(k);
            else tick(k);
            n_checks++;
            if ({LEVEL, PRESS, RELEASE} !== {m_level, m_press, m_release} || (PRESS && RELEASE))
                $display("FAIL random n%0d: got LPR=%b%b%b want %b%b%b", n, LEVEL, PRESS, RELEASE,
                         m_level, m_press, m_release);
            else n_pass++;
        end
    endtask

    initial begin
        RST   = 1'b0;
        KEY_N = 1'b1;
        model_reset();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_mid_reset();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
